// File: rtl/mips_pkg.sv
// Shared tinymips encodings: opcodes, funct codes, ALU controls, control selects and FSM states.
// The ILLEGAL state exists only when MIPS_MC_ILLEGAL_TRAP_EN is defined.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    ,
    S_ILLEGAL = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       mem2reg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
  } ctrl_t;

  // State entered from DECODE; unknown opcodes either trap or fall back to FETCH as a NOP.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = S_RTYPEEX;
      OP_BEQ:       decode_target = S_BEQEX;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_J:         decode_target = S_JEX;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      default:      decode_target = S_ILLEGAL;
`else
      default:      decode_target = S_FETCH;
`endif
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps (aluop, funct) to the 3-bit ALU operation; purely combinational, no handshake.
// Unrecognised funct codes fall back to add.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle tinymips controller: Moore FSM, outputs combinational from state (alu_control also from funct).
// Enables are gated off while RST_N is low; MIPS_MC_ILLEGAL_TRAP_EN adds a sticky ILLEGAL trap state.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       mem2reg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alu_control,
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   is_lw_q;
  ctrl_t  ctrl;

  // lw/sw choice is latched in DECODE so later opcode changes cannot redirect MEMADR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_lw_q <= (opcode == OP_LW);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl       = '0;
    ctrl.aluop = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        state_d      = decode_target(opcode);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem2reg  = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
        state_d      = S_FETCH;
      end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .aluop       (ctrl.aluop),
    .funct       (funct),
    .alu_control (alu_control)
  );

  // Reset gating keeps a half-finished instruction from writing anything.
  assign pc_en    = RST_N & (ctrl.pcwrite | (ctrl.branch & zero));
  assign memwrite = RST_N & ctrl.memwrite;
  assign irwrite  = RST_N & ctrl.irwrite;
  assign regwrite = RST_N & ctrl.regwrite;
  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign mem2reg  = ctrl.mem2reg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = state_q;

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
  assign illegal_op = RST_N & (state_q == S_ILLEGAL);
`endif

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle main controller for the tinymips core: a Moore FSM that decodes the 6-bit opcode (and funct, via an ALU sub-decoder) of the instruction held in the instruction register. It sequences the shared datapath through fetch, decode, execute, memory and writeback steps. It is the decoding end of the instruction encodings the bench produces for lw/sw, R-type, beq, addi and j, and replaces forced control signals with real ones.

## Interface
- Parameters: none. Opcode, funct and state encodings come from the shared package.
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag (beq compare result)
- pc_en  out  1  PC load = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALU out
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 1 = rd, 0 = rt
- mem2reg  out  1  writeback select: 1 = memory data, 0 = ALU out
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm << 2
- pcsrc  out  2  next PC select: 00 = ALU result, 01 = ALU out, 10 = jump target
- alu_control  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current FSM state, for debug and verification
- illegal_op  out  1  trap flag; present only with the macro (see Configuration)

## Operation
- Opcode values: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, plus ILLEGAL when the macro is defined.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for lw/sw, RTYPEEX for R, BEQEX for beq, ADDIEX for addi, JEX for j.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX → FETCH.
- Any output not listed for a state is 0.
  - FETCH: iord = 0, irwrite = 1, alusrca = 0, alusrcb = 01, aluop = add, pcsrc = 00, pcwrite = 1.
  - DECODE: alusrca = 0, alusrcb = 11, aluop = add (computes the branch target).
  - MEMADR and ADDIEX: alusrca = 1, alusrcb = 10, aluop = add.
  - MEMRD: iord = 1.
  - MEMWB: regdst = 0, mem2reg = 1, regwrite = 1.
  - MEMWR: iord = 1, memwrite = 1.
  - RTYPEEX: alusrca = 1, alusrcb = 00, aluop = funct.
  - RTYPEWB: regdst = 1, mem2reg = 0, regwrite = 1.
  - BEQEX: alusrca = 1, alusrcb = 00, aluop = sub, pcsrc = 01, branch = 1.
  - ADDIWB: regdst = 0, mem2reg = 0, regwrite = 1.
  - JEX: pcsrc = 10, pcwrite = 1.
- ALU decode:
  - aluop add → 010; aluop sub → 110.
  - aluop funct: 0x20 → 010, 0x22 → 110, 0x24 → 000, 0x25 → 001, 0x2A → 111.
  - Any other funct → 010.
- Unknown opcode in DECODE: see Configuration.

## Timing
- state is a register; all outputs are combinational from state (Moore). alu_control additionally depends on funct.
- Cycles per instruction, counted from entering FETCH to re-entering FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Reset:
  - RST_N low immediately forces state = FETCH.
  - While RST_N is low, every enable (pc_en, memwrite, irwrite, regwrite) and illegal_op is forced to 0 combinationally.
  - Select outputs take their FETCH values during reset.
  - The first FETCH enables assert in the first full cycle after RST_N rises.
- Reset asserted mid-instruction: the instruction is abandoned with no partial write. Any write enable drops in the same delta as RST_N falls.
- opcode and funct are sampled in DECODE only. Changes in later states do not alter the path taken, except that alu_control follows funct in RTYPEEX.
- beq: pc_en = zero, valid only in BEQEX.

## Configuration
- MIPS_MC_ILLEGAL_TRAP_EN defined:
  - Unknown opcode in DECODE → ILLEGAL.
  - ILLEGAL holds all enables at 0 and illegal_op = 1.
  - It stays in ILLEGAL until reset.
- MIPS_MC_ILLEGAL_TRAP_EN undefined:
  - Unknown opcode in DECODE → FETCH, so the instruction executes as a 2-cycle NOP.
  - The ILLEGAL state and the illegal_op port are absent.

## Structure
- Package mips_pkg holds the opcode localparams, the funct codes, the alu_control codes, the aluop enum (add, sub, funct) and the state enum (4-bit encoding).
- One combinational sub-module, mips_alu_decoder, maps (aluop, funct) to alu_control. The FSM stays in mips_mc_ctrl.

## Test plan
- lw, instruction 0x8C220004:
  - state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - regwrite = 1 and mem2reg = 1 only in MEMWB; iord = 1 in MEMRD.
- sw, instruction 0xAC850000: 4 cycles; memwrite = 1 exactly once, in MEMWR with iord = 1; regwrite is never 1.
- R-type with funct 0x20, 0x22, 0x24, 0x25, 0x2A:
  - alu_control in RTYPEEX is 010, 110, 000, 001, 111 respectively.
  - RTYPEWB has regdst = 1 and regwrite = 1.
- beq, opcode 000100:
  - zero = 1 → pc_en = 1 in BEQEX with pcsrc = 01.
  - zero = 0 → pc_en = 0.
  - Either way, back in FETCH after 3 cycles.
- Opcode 111111:
  - with the macro → ILLEGAL, illegal_op = 1, held for 20 cycles, cleared by RST_N.
  - without the macro → FETCH 2 cycles after FETCH, with no writes.
- RST_N pulled low during MEMRD of a lw: state = FETCH immediately, MEMWB never occurs, all enables are 0 while low, and FETCH resumes normally after release.
